// File: rtl/mips16_pkg.sv
// Shared types and constants for the MIPS16 memory-side responder and its benches.
package mips16_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  // Datapath word width and default RAM index width
  localparam int MEM_DATA_W = 16;
  localparam int MEM_ADDR_W = 8;

  // Load/store opcodes, handy for benches that drive the responder like the datapath does
  localparam logic [3:0] LW = 4'b1000;
  localparam logic [3:0] SW = 4'b1001;

  // True when a 16-bit word address fits inside a RAM of 2**aw words
  function automatic logic addr_in_range(input logic [15:0] a, input int aw);
    return (a >> aw) == 16'd0;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM: write on we, registered read data on re.
module mem_array
  import mips16_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clock,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Storage is never reset; contents survive a responder reset
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle MIPS16 datapath.
// Accepts one read or write at a time, waits LATENCY cycles, touches the RAM,
// then pulses ready for one cycle. Malformed or out-of-range requests get an
// err pulse instead and never reach the RAM.
module mem_responder
  import mips16_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [15:0]       address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  // Counter reload value; LATENCY is limited to 1..15 so it fits in four bits
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  mem_state_t        state;
  mem_state_t        next_state;
  logic [3:0]        cnt;
  logic              issued;
  logic              op_write;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] ram_rdata;

  logic              accept;
  logic              reject;
  logic              ram_we;
  logic              ram_re;
  logic              capture;
  logic              single_req;
  logic              any_req;
  logic              in_range;

  assign single_req = mem_read ^ mem_write;
  assign any_req    = mem_read | mem_write;
  assign in_range   = addr_in_range(address, ADDR_W);

  // State register; reset drops any in-flight access on the floor
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and control decode. The RAM is touched once the countdown hits
  // zero; the following edge moves its registered output into read_data and
  // enters DONE, so ready lands LATENCY+1 edges after the accept edge.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    reject     = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    capture    = 1'b0;
    ready      = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (single_req && in_range) begin
          accept     = 1'b1;
          next_state = WAIT;
        end else if (any_req) begin
          reject = 1'b1;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (cnt == 4'd0) begin
          if (!issued) begin
            ram_we = op_write;
            ram_re = !op_write;
          end else begin
            capture    = 1'b1;
            next_state = DONE;
          end
        end
      end
      DONE: begin
        busy       = 1'b1;
        ready      = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Request latches, latency countdown, error pulse and load-data register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt       <= 4'd0;
      issued    <= 1'b0;
      op_write  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      read_data <= '0;
      err       <= 1'b0;
    end else begin
      err <= reject;
      if (accept) begin
        op_write <= mem_write;
        addr_q   <= address[ADDR_W-1:0];
        wdata_q  <= write_data;
        cnt      <= LAT_M1;
        issued   <= 1'b0;
      end else if (state == WAIT) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else begin
          issued <= 1'b1;
        end
      end
      if (capture && !op_write) begin
        read_data <= ram_rdata;
      end
    end
  end

  mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem_array (
    .clock(clock),
    .we   (ram_we),
    .re   (ram_re),
    .addr (addr_q),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (LATENCY 2, 1, 15) checked against a
// behavioural word-memory model with directed and randomized accesses.
module tb_mem_responder;

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 15);
  endfunction

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [2:0]       reset;
  logic [2:0]       mem_read;
  logic [2:0]       mem_write;
  logic [2:0][15:0] address;
  logic [2:0][15:0] write_data;
  logic [2:0][15:0] read_data;
  logic [2:0]       ready;
  logic [2:0]       busy;
  logic [2:0]       err;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder #(
      .ADDR_W (8),
      .DATA_W (16),
      .LATENCY(lat_of(g))
    ) dut (
      .clock     (clock),
      .reset     (reset[g]),
      .mem_read  (mem_read[g]),
      .mem_write (mem_write[g]),
      .address   (address[g]),
      .write_data(write_data[g]),
      .read_data (read_data[g]),
      .ready     (ready[g]),
      .busy      (busy[g]),
      .err       (err[g])
    );
  end

  int errors = 0;
  int checks = 0;

  // Reference model: plain word store per instance plus the last loaded word
  logic [15:0] mmem [3][256];
  logic [15:0] exp_rd [3];
  logic [7:0]  written [$];

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after an accept edge; counts edges until ready is seen
  task automatic wait_ready(input int k, input int exp_cycles, input string tag);
    int n;
    n = 0;
    while (ready[k] !== 1'b1 && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    check_output(tag, n, exp_cycles);
  endtask

  // One complete request on instance k, checked against the model
  task automatic apply_stimulus(input int k, input bit rd, input bit wr,
                                input logic [15:0] addr, input logic [15:0] wd);
    bit rej;
    rej = (rd && wr) || ((addr >> 8) != 16'd0);
    @(negedge clock);
    mem_read[k]   = rd;
    mem_write[k]  = wr;
    address[k]    = addr;
    write_data[k] = wd;
    @(posedge clock); #1;
    mem_read[k]  = 1'b0;
    mem_write[k] = 1'b0;
    if (rej) begin
      check_output("rej_err", err[k], 1);
      check_output("rej_busy", busy[k], 0);
      check_output("rej_ready", ready[k], 0);
      @(posedge clock); #1;
      check_output("rej_err_clear", err[k], 0);
      check_output("rej_rdata_hold", read_data[k], exp_rd[k]);
    end else begin
      check_output("acc_busy", busy[k], 1);
      check_output("acc_err", err[k], 0);
      wait_ready(k, lat_of(k) + 1, "ready_latency");
      if (rd) exp_rd[k] = mmem[k][addr[7:0]];
      else    mmem[k][addr[7:0]] = wd;
      check_output("done_rdata", read_data[k], exp_rd[k]);
      check_output("done_busy", busy[k], 1);
      @(posedge clock); #1;
      check_output("idle_ready", ready[k], 0);
      check_output("idle_busy", busy[k], 0);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] a;
    logic [15:0] d;
    reset      = 3'b111;
    mem_read   = '0;
    mem_write  = '0;
    address    = '0;
    write_data = '0;
    for (int k = 0; k < 3; k++) exp_rd[k] = 16'h0000;

    repeat (2) @(posedge clock);
    #1;
    for (int k = 0; k < 3; k++) begin
      check_output("reset_rdata", read_data[k], 0);
      check_output("reset_ready", ready[k], 0);
      check_output("reset_busy", busy[k], 0);
      check_output("reset_err", err[k], 0);
    end
    @(negedge clock);
    reset = 3'b000;

    $display("[TB] write/read directed");
    apply_stimulus(0, 0, 1, 16'h0010, 16'hBEEF);
    apply_stimulus(0, 1, 0, 16'h0010, 16'h0000);
    check_output("beef_readback", read_data[0], 16'hBEEF);

    $display("[TB] rejected requests");
    apply_stimulus(0, 0, 1, 16'h0004, 16'h0A0A);
    apply_stimulus(0, 1, 0, 16'h0010, 16'h0000);
    apply_stimulus(0, 1, 1, 16'h0004, 16'hFFFF);
    apply_stimulus(0, 1, 0, 16'h0004, 16'h0000);
    check_output("both_strobes_ram", read_data[0], 16'h0A0A);
    apply_stimulus(0, 1, 0, 16'h0100, 16'h0000);
    apply_stimulus(0, 0, 1, 16'hFF04, 16'h7777);
    apply_stimulus(0, 1, 0, 16'h0004, 16'h0000);
    check_output("oor_write_ram", read_data[0], 16'h0A0A);

    $display("[TB] reset during write wait");
    apply_stimulus(0, 0, 1, 16'h0020, 16'h5555);
    apply_stimulus(0, 1, 0, 16'h0010, 16'h0000);
    @(negedge clock);
    mem_write[0]  = 1'b1;
    address[0]    = 16'h0020;
    write_data[0] = 16'h1234;
    @(posedge clock); #1;
    mem_write[0] = 1'b0;
    check_output("abort_busy_pre", busy[0], 1);
    #2 reset[0] = 1'b1;
    #1;
    check_output("abort_busy", busy[0], 0);
    check_output("abort_ready", ready[0], 0);
    check_output("abort_err", err[0], 0);
    check_output("abort_rdata", read_data[0], 0);
    exp_rd[0] = 16'h0000;
    @(negedge clock);
    reset[0] = 1'b0;
    apply_stimulus(0, 1, 0, 16'h0020, 16'h0000);
    check_output("abort_old_value", read_data[0], 16'h5555);

    $display("[TB] strobe held through done");
    @(negedge clock);
    mem_read[0] = 1'b1;
    address[0]  = 16'h0010;
    @(posedge clock); #1;
    wait_ready(0, 3, "held_latency1");
    check_output("held_rdata1", read_data[0], 16'hBEEF);
    @(posedge clock); #1;
    check_output("held_gap_busy", busy[0], 0);
    check_output("held_gap_ready", ready[0], 0);
    @(posedge clock); #1;
    check_output("held_reaccept_busy", busy[0], 1);
    mem_read[0] = 1'b0;
    wait_ready(0, 3, "held_latency2");
    @(posedge clock); #1;
    check_output("held_end_busy", busy[0], 0);
    exp_rd[0] = 16'hBEEF;

    $display("[TB] randomized accesses");
    written.push_back(8'h10);
    written.push_back(8'h04);
    written.push_back(8'h20);
    for (int i = 0; i < 24; i++) begin
      a = 16'($urandom_range(0, 255));
      d = 16'($urandom);
      case ($urandom_range(0, 3))
        0: apply_stimulus(0, 1, 0, a | 16'h0100, d);
        1: apply_stimulus(0, 1, 1, a, d);
        default: begin
          apply_stimulus(0, 0, 1, a, d);
          written.push_back(a[7:0]);
        end
      endcase
      a = {8'h00, written[$urandom_range(0, written.size() - 1)]};
      apply_stimulus(0, 1, 0, a, 16'h0000);
    end

    $display("[TB] latency 1 and 15 builds");
    for (int k = 1; k < 3; k++) begin
      for (int j = 0; j < 8; j++) begin
        apply_stimulus(k, 0, 1, 16'(j), 16'($urandom));
      end
      for (int j = 0; j < 8; j++) begin
        apply_stimulus(k, 1, 0, 16'(j), 16'h0000);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
